iobuf_turnaround_arb: RTL and testbench
=======================================

# iobuf_turnaround_arb

Two-port arbiter and turnaround sequencer for a shared bidirectional pad bus built from tri-state I/O buffers. It drives the pad buffer's input (`PAD_I`) and tri-state control (`PAD_T`, 1 = high-Z) and samples its output (`PAD_O`). It grants bursts to two requesters round-robin and inserts guaranteed high-Z turnaround cycles between bursts, so two drivers never contend on the pad.

## Interface
Parameters:
- `WIDTH`, 8: pad bus width.
- `MAX_BURST`, 4: maximum beats per grant (1..15).
- `TURN_CYC`, 1: turnaround cycles after each burst (0..7).

Ports:
- `C`  in  1  clock, rising edge.
- `CLR_N`  in  1  reset, asynchronous, active-low.
- `REQ0`, `REQ1`  in  1  request / beat-valid per port.
- `WE0`, `WE1`  in  1  beat direction: 1 = drive pad, 0 = sample pad.
- `D0`, `D1`  in  WIDTH  write data.
- `GNT0`, `GNT1`  out  1  grant, registered.
- `Q0`, `Q1`  out  WIDTH  read data, registered.
- `QV0`, `QV1`  out  1  read data valid, one-cycle pulse.
- `PAD_T`  out  1  to buffer `T`; 0 = drive, 1 = high-Z; registered.
- `PAD_I`  out  WIDTH  to buffer `I`; registered.
- `PAD_O`  in  WIDTH  from buffer `O`.

## Operation
- States: IDLE, OWN, TURN. Registers: state, owner, `LAST` (last granted port), beat counter, burst direction, turn counter.
- Reset (async, immediate): state IDLE, `GNT0`=`GNT1`=0, `PAD_T`=1, `PAD_I`=0, `Q0`=`Q1`=0, `QV0`=`QV1`=0, `LAST`=1, all counters 0.
- IDLE, on an edge where any REQ is high:
  - Grant the requester; if both are high, grant the port that is not `LAST`.
  - Set `GNTx`=1, owner=x, `LAST`=x, beats=0, state OWN.
  - The burst direction is latched from `WEx` at the grant edge.
- OWN: a beat is accepted on an edge where `GNTx`=1, `REQx`=1 and `WEx` equals the latched direction.
  - Write beat: `PAD_I`<=`Dx`, `PAD_T`<=0.
  - Read beat: `PAD_T`<=1; on the following edge `Qx`<=`PAD_O` and `QVx`<=1 for one cycle.
  - On any edge without an accepted write beat: `PAD_T`<=1. `PAD_I` holds its value.
- The burst ends on the edge where any of these holds:
  - `REQx`=0: no beat is accepted.
  - `WEx` differs from the latched direction: no beat is accepted; the requester must re-request.
  - The accepted beat brings the count to `MAX_BURST`: that beat is accepted.
- At burst end: `GNTx`<=0; state <= TURN with counter=`TURN_CYC`, or IDLE directly when `TURN_CYC`=0.
- TURN: `PAD_T` stays 1, the counter decrements each cycle, and the state goes to IDLE when it reaches 1. REQs are ignored in TURN.
- The non-owner's REQ is ignored until IDLE. A request from the previous owner is eligible again in IDLE under round-robin.
- `GNT0` and `GNT1` are never both 1. `QV` asserts only for the port whose read beat produced it.

## Timing
- Grant latency: REQ sampled high in IDLE at edge e gives GNT high after e. The earliest beat accept is edge e+1.
- Write: accepted at edge a → pad driven in cycle (a, a+1).
- Read: accepted at edge a → `PAD_T`=1 during (a, a+1); `Qx`/`QVx` valid during (a+1, a+2).
- Throughput: one beat per cycle within a burst.
- Turnaround guarantee: between any two cycles with `PAD_T`=0 belonging to different bursts, at least `TURN_CYC`+1 cycles have `PAD_T`=1. The same minimum holds between the last read sample and the next drive.
- Minimum gap between bursts: `TURN_CYC`+1 cycles of no grant (TURN plus one IDLE cycle).
- Reset mid-burst: `PAD_T`=1 and `GNT`=0 immediately; a pending `QV` is dropped.

## Test plan
- Reset: assert `CLR_N`=0 mid-write-burst → `PAD_T`=1, `GNT0`=`GNT1`=0, `QV0`=`QV1`=0 before the next edge. Release → IDLE with no spurious grant.
- Single write (WIDTH=8): `REQ0`=1, `WE0`=1, `D0`=0xA5 held one beat past grant, then `REQ0`=0 → exactly one cycle with `PAD_T`=0 and `PAD_I`=0xA5; `GNT0` high for 2 cycles.
- Read capture: port 1 read burst of 3 beats with `PAD_O`=0x11, 0x22, 0x33 on successive cycles → `QV1` high 3 consecutive cycles carrying `Q1`=0x11, 0x22, 0x33; `PAD_T` stays 1 throughout.
- MAX_BURST cut plus turnaround (`MAX_BURST`=4, `TURN_CYC`=2): both ports hold write REQ → port 0 gets 4 beats, then ≥3 cycles with `PAD_T`=1, then port 1 gets 4 beats; the pattern alternates.
- Round-robin tie after reset: `REQ0` and `REQ1` rise on the same edge → port 0 is granted first; after its burst, port 1 is granted even if `REQ0` stays high.
- Direction flip: port 0 write burst with `WE0` dropping to 0 on beat 2 → that beat is not accepted, `GNT0` drops, TURN follows, then port 0 is re-granted as a read burst.

Source files
------------

// File: rtl/iobuf_turnaround_arb.sv
// Two-port round-robin arbiter for a shared tri-state pad bus, with a guaranteed
// high-Z turnaround window between bursts.
module iobuf_turnaround_arb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned TURN_CYC  = 1
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             WE0,
    input  logic             WE1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic             QV0,
    output logic             QV1,
    output logic             PAD_T,
    output logic [WIDTH-1:0] PAD_I,
    input  logic [WIDTH-1:0] PAD_O
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOwn  = 2'd1;
    localparam logic [1:0] StTurn = 2'd2;

    localparam logic [3:0] MaxBeats = 4'(MAX_BURST);
    localparam logic [2:0] TurnCyc  = 3'(TURN_CYC);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [3:0]       beats_q, beats_d;
    logic             dir_q, dir_d;
    logic [2:0]       turn_q, turn_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             pad_t_q, pad_t_d;
    logic [WIDTH-1:0] pad_i_q, pad_i_d;
    logic             rd_pend_q, rd_pend_d, rd_port_q, rd_port_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
    logic             qv0_q, qv0_d, qv1_q, qv1_d;

    logic             own_req, own_we, accept, sel;
    logic [WIDTH-1:0] own_data;

    assign own_req  = owner_q ? REQ1 : REQ0;
    assign own_we   = owner_q ? WE1 : WE0;
    assign own_data = owner_q ? D1 : D0;
    // A direction change mid-burst is not a beat; it closes the burst instead.
    assign accept   = own_req && (own_we == dir_q);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        beats_d   = beats_q;
        dir_d     = dir_q;
        turn_d    = turn_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        pad_t_d   = 1'b1;
        pad_i_d   = pad_i_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        qv0_d     = 1'b0;
        qv1_d     = 1'b0;
        sel       = 1'b0;

        // Read data is sampled one edge after the read beat was accepted.
        if (rd_pend_q) begin
            if (rd_port_q) begin
                q1_d  = PAD_O;
                qv1_d = 1'b1;
            end else begin
                q0_d  = PAD_O;
                qv0_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (REQ0 || REQ1) begin
                    sel     = (REQ0 && REQ1) ? ~last_q : REQ1;
                    owner_d = sel;
                    last_d  = sel;
                    beats_d = '0;
                    dir_d   = sel ? WE1 : WE0;
                    gnt0_d  = ~sel;
                    gnt1_d  = sel;
                    state_d = StOwn;
                end
            end
            StOwn: begin
                if (accept) begin
                    beats_d = beats_q + 4'd1;
                    if (dir_q) begin
                        pad_t_d = 1'b0;
                        pad_i_d = own_data;
                    end else begin
                        rd_pend_d = 1'b1;
                        rd_port_d = owner_q;
                    end
                end
                if (!accept || (beats_q + 4'd1 == MaxBeats)) begin
                    gnt0_d = 1'b0;
                    gnt1_d = 1'b0;
                    if (TurnCyc == 3'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StTurn;
                        turn_d  = TurnCyc;
                    end
                end
            end
            StTurn: begin
                if (turn_q <= 3'd1) begin
                    turn_d  = '0;
                    state_d = StIdle;
                end else begin
                    turn_d = turn_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            beats_q   <= '0;
            dir_q     <= 1'b0;
            turn_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            pad_t_q   <= 1'b1;
            pad_i_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            q0_q      <= '0;
            q1_q      <= '0;
            qv0_q     <= 1'b0;
            qv1_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            beats_q   <= beats_d;
            dir_q     <= dir_d;
            turn_q    <= turn_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            pad_t_q   <= pad_t_d;
            pad_i_q   <= pad_i_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            q0_q      <= q0_d;
            q1_q      <= q1_d;
            qv0_q     <= qv0_d;
            qv1_q     <= qv1_d;
        end
    end

    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign Q0    = q0_q;
    assign Q1    = q1_q;
    assign QV0   = qv0_q;
    assign QV1   = qv1_q;
    assign PAD_T = pad_t_q;
    assign PAD_I = pad_i_q;

endmodule

// File: tb/tb_iobuf_turnaround_arb.sv
// Bench for iobuf_turnaround_arb: directed scenarios plus a randomized run against a
// burst/cooldown reference model.
module tb_iobuf_turnaround_arb;

    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int TURN = 2;
    localparam int SLOT = MAXB + TURN + 1;

    logic         c = 1'b0;
    logic         clr_n = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0, pad_o = '0;
    logic         gnt0, gnt1, qv0, qv1, pad_t;
    logic [W-1:0] q0, q1, pad_i;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state: one active burst (or none) and a no-grant cooldown.
    int           m_owner, m_last, m_beats, m_cool, m_rd;
    logic         m_dir, m_qv0, m_qv1, m_padt;
    logic [W-1:0] m_q0, m_q1, m_padi;

    always #5 c = ~c;

    iobuf_turnaround_arb #(
        .WIDTH    (W),
        .MAX_BURST(MAXB),
        .TURN_CYC (TURN)
    ) dut (
        .C    (c),
        .CLR_N(clr_n),
        .REQ0 (req0),
        .REQ1 (req1),
        .WE0  (we0),
        .WE1  (we1),
        .D0   (d0),
        .D1   (d1),
        .GNT0 (gnt0),
        .GNT1 (gnt1),
        .Q0   (q0),
        .Q1   (q1),
        .QV0  (qv0),
        .QV1  (qv1),
        .PAD_T(pad_t),
        .PAD_I(pad_i),
        .PAD_O(pad_o)
    );

    task automatic nxt();
        @(posedge c);
        @(negedge c);
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; d0 = '0; d1 = '0; pad_o = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr_n = 0;
        nxt();
        clr_n = 1;
        nxt();
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_beats = 0; m_cool = 0; m_rd = -1;
        m_dir = 0; m_qv0 = 0; m_qv1 = 0; m_padt = 1;
        m_q0 = '0; m_q1 = '0; m_padi = '0;
    endtask

    task automatic model_step();
        logic r, w;
        logic [W-1:0] d;
        m_qv0 = 0;
        m_qv1 = 0;
        if (m_rd == 0) begin m_q0 = pad_o; m_qv0 = 1; end
        if (m_rd == 1) begin m_q1 = pad_o; m_qv1 = 1; end
        m_rd = -1;
        m_padt = 1;
        if (m_owner < 0) begin
            if (m_cool > 0) m_cool--;
            else if (req0 || req1) begin
                m_owner = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
                m_last  = m_owner;
                m_dir   = (m_owner == 1) ? we1 : we0;
                m_beats = 0;
            end
        end else begin
            r = (m_owner == 1) ? req1 : req0;
            w = (m_owner == 1) ? we1 : we0;
            d = (m_owner == 1) ? d1 : d0;
            if (r && w == m_dir) begin
                m_beats++;
                if (m_dir) begin m_padt = 0; m_padi = d; end
                else m_rd = m_owner;
                if (m_beats == MAXB) begin m_owner = -1; m_cool = TURN; end
            end else begin
                m_owner = -1;
                m_cool  = TURN;
            end
        end
    endtask

    task automatic test_reset();
        int spurious;
        idle_inputs();
        #2 clr_n = 0;
        nxt();
        n_total++;
        if ({gnt0, gnt1, pad_t, qv0, qv1} !== 5'b00100)
            $display("FAIL reset_ctl: gnt0=%b gnt1=%b pad_t=%b qv=%b%b want 0 0 1 00",
                     gnt0, gnt1, pad_t, qv0, qv1);
        else n_pass++;
        n_total++;
        if ({pad_i, q0, q1} !== '0)
            $display("FAIL reset_data: pad_i=%h q0=%h q1=%h want 0", pad_i, q0, q1);
        else n_pass++;
        clr_n = 1;
        nxt();
        req0 = 1; we0 = 1; d0 = 8'h3C;
        nxt();
        nxt();
        n_total++;
        if (pad_t !== 1'b0) $display("FAIL reset_pre_drive: pad_t=%b want 0", pad_t);
        else n_pass++;
        #2 clr_n = 0;
        #1;
        n_total++;
        if ({gnt0, gnt1, pad_t, qv0, qv1} !== 5'b00100)
            $display("FAIL reset_async: gnt0=%b gnt1=%b pad_t=%b qv=%b%b want 0 0 1 00",
                     gnt0, gnt1, pad_t, qv0, qv1);
        else n_pass++;
        req0 = 0; we0 = 0;
        @(negedge c);
        clr_n = 1;
        spurious = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (gnt0 || gnt1) spurious++;
        end
        n_total++;
        if (spurious != 0) $display("FAIL reset_no_grant: grant cycles=%0d want 0", spurious);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int gcnt, lcnt;
        logic [W-1:0] seen;
        do_reset();
        gcnt = 0; lcnt = 0; seen = '0;
        req0 = 1; we0 = 1; d0 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            nxt();
            if (gnt0) gcnt++;
            if (!pad_t) begin lcnt++; seen = pad_i; end
            if (i == 1) req0 = 0;
        end
        n_total++;
        if (gcnt != 2) $display("FAIL sw_gnt_cycles: got %0d want 2", gcnt);
        else n_pass++;
        n_total++;
        if (lcnt != 1 || seen !== 8'hA5)
            $display("FAIL sw_drive: low cycles=%0d pad_i=%h want 1 a5", lcnt, seen);
        else n_pass++;
    endtask

    task automatic test_read_capture();
        logic exp_qv;
        logic [W-1:0] exp_q;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req1 = (k <= 3); we1 = 0;
            pad_o = (k == 2) ? 8'h11 : (k == 3) ? 8'h22 : (k == 4) ? 8'h33 : 8'hEE;
            nxt();
            if (k == 0) begin
                n_total++;
                if (gnt1 !== 1'b1 || gnt0 !== 1'b0)
                    $display("FAIL rd_grant: gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
                else n_pass++;
            end
            exp_qv = (k >= 2 && k <= 4);
            exp_q  = (k == 2) ? 8'h11 : (k == 3) ? 8'h22 : 8'h33;
            n_total++;
            if (pad_t !== 1'b1 || qv1 !== exp_qv || qv0 !== 1'b0 || (exp_qv && q1 !== exp_q))
                $display("FAIL rd_cap k=%0d: pad_t=%b qv0=%b qv1=%b q1=%h want 1 0 %b %h",
                         k, pad_t, qv0, qv1, q1, exp_qv, exp_q);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_burst_cut();
        int p, off, run, prev_low_seen;
        logic eg0, eg1, elow;
        do_reset();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; d0 = 8'h5A; d1 = 8'hC3;
        run = 0; prev_low_seen = 0;
        for (int k = 0; k < 4 * SLOT; k++) begin
            nxt();
            p    = k % (2 * SLOT);
            off  = p % SLOT;
            eg0  = (p < SLOT) && (off < MAXB);
            eg1  = (p >= SLOT) && (off < MAXB);
            elow = (off >= 1) && (off <= MAXB);
            n_total++;
            if ({gnt0, gnt1, pad_t} !== {eg0, eg1, ~elow} ||
                (elow && pad_i !== ((p < SLOT) ? 8'h5A : 8'hC3)))
                $display("FAIL cut k=%0d: gnt0=%b gnt1=%b pad_t=%b pad_i=%h want %b %b %b",
                         k, gnt0, gnt1, pad_t, pad_i, eg0, eg1, ~elow);
            else n_pass++;
            if (pad_t) run++;
            else begin
                if (prev_low_seen && run > 0) begin
                    n_total++;
                    if (run < TURN + 1)
                        $display("FAIL cut_gap k=%0d: high-Z run=%0d want >=%0d", k, run, TURN + 1);
                    else n_pass++;
                end
                prev_low_seen = 1;
                run = 0;
            end
        end
        idle_inputs();
    endtask

    task automatic test_rr_tie();
        bit seen;
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        nxt();
        n_total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0)
            $display("FAIL rr_first: gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (!gnt0) begin seen = 1; break; end
        end
        n_total++;
        if (!seen) $display("FAIL rr_release: gnt0 stuck=%b want 0 within 20", gnt0);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (gnt0 || gnt1) begin seen = 1; break; end
        end
        n_total++;
        if (!seen || gnt1 !== 1'b1 || gnt0 !== 1'b0)
            $display("FAIL rr_second: gnt0=%b gnt1=%b seen=%0d want 0 1 1", gnt0, gnt1, seen);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_dir_flip();
        logic eg, elow;
        do_reset();
        req0 = 1; d0 = 8'h77; pad_o = 8'h9D;
        for (int k = 0; k < 8; k++) begin
            we0 = (k < 2);
            nxt();
            eg   = (k <= 1) || (k >= 5);
            elow = (k == 1);
            n_total++;
            if (gnt0 !== eg || pad_t !== ~elow || gnt1 !== 1'b0 || qv0 !== (k == 7))
                $display("FAIL flip k=%0d: gnt0=%b pad_t=%b gnt1=%b qv0=%b want %b %b 0 %b",
                         k, gnt0, pad_t, gnt1, qv0, eg, ~elow, (k == 7));
            else n_pass++;
        end
        n_total++;
        if (q0 !== 8'h9D) $display("FAIL flip_q0: q0=%h want 9d", q0);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [28:0] exp_v, act_v;
        int errs;
        do_reset();
        model_reset();
        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            req0 = ($urandom_range(0, 4) != 0);
            req1 = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) we0 = ~we0;
            if ($urandom_range(0, 7) == 0) we1 = ~we1;
            d0 = W'($urandom); d1 = W'($urandom); pad_o = W'($urandom);
            nxt();
            model_step();
            exp_v = {m_owner == 0, m_owner == 1, m_padt, m_padi, m_qv0, m_qv1, m_q0, m_q1};
            act_v = {gnt0, gnt1, pad_t, pad_i, qv0, qv1, q0, q1};
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL random cyc=%0d: got %h want %h", i, act_v, exp_v);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_capture();
        test_burst_cut();
        test_rr_tie();
        test_dir_flip();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
